// File: rtl/vending_input_conditioner.sv
// vending_input_conditioner
//   Front end for the coin/selection vending FSM. Each raw pad code goes
//   through a synchroniser and a debouncer. A clean 00 -> X press on the
//   debounced code becomes a single event. The event is held until the slow
//   FSM consumes it with a one-cycle 'take' strobe.
//
//   Build option: define COIN_FIFO_EN to turn coin storage into a 4-entry
//   FIFO. Without it, coin storage is a single holding register.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   coin_raw     raw coin code (00 none, 01/10/11 denominations)
//   sel_raw      raw selection code (00 none, 01/10/11 product)
//   take         one-cycle strobe: downstream FSM sampled the outputs
//   coin_code    head coin event, 00 when nothing pending
//   coin_pending at least one coin event held
//   sel_code     held selection event, 00 when none
//   overflow     sticky, a coin event was dropped; cleared only by reset

// Per-channel conditioner: 2-flop sync, debounce, rising-event detect.
module vic_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] raw,
  output logic       ev,
  output logic [1:0] code
);
  localparam logic [15:0] CNT_MAX = 16'(DEBOUNCE_CYCLES - 1);
  // stable follows candidate on the same edge the counter reaches CNT_MAX,
  // so the test is made on the pre-increment value.
  localparam logic [15:0] CNT_THR = 16'(DEBOUNCE_CYCLES - 2);

  logic [1:0]  sync1, sync2, cand, stable, stable_d;
  logic [15:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1    <= '0;
      sync2    <= '0;
      cand     <= '0;
      stable   <= '0;
      stable_d <= '0;
      cnt      <= '0;
    end else begin
      sync1    <= raw;
      sync2    <= sync1;
      stable_d <= stable;
      if (sync2 != cand) begin
        cand <= sync2;
        cnt  <= '0;
      end else begin
        if (cnt != CNT_MAX) cnt <= cnt + 16'd1;
        if (cnt >= CNT_THR) stable <= cand;
      end
    end
  end

  // Only 00 -> X counts. A direct X -> Y change has stable_d nonzero.
  assign ev   = (stable != 2'b00) && (stable_d == 2'b00);
  assign code = stable;
endmodule

module vending_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] coin_raw,
  input  logic [1:0] sel_raw,
  input  logic       take,
  output logic [1:0] coin_code,
  output logic       coin_pending,
  output logic [1:0] sel_code,
  output logic       overflow
);
  localparam int NUM_CH  = 2;
  localparam int CH_COIN = 0;
  localparam int CH_SEL  = 1;

  logic [NUM_CH-1:0][1:0] ch_raw, ch_code;
  logic [NUM_CH-1:0]      ch_ev;

  assign ch_raw[CH_COIN] = coin_raw;
  assign ch_raw[CH_SEL]  = sel_raw;

  generate
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      vic_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
        .clk  (clk),
        .rst_n(rst_n),
        .raw  (ch_raw[g]),
        .ev   (ch_ev[g]),
        .code (ch_code[g])
      );
    end
  endgenerate

  logic       coin_ev, sel_ev;
  logic [1:0] coin_val, sel_val;
  logic       pop;

  assign coin_ev  = ch_ev[CH_COIN];
  assign coin_val = ch_code[CH_COIN];
  assign sel_ev   = ch_ev[CH_SEL];
  assign sel_val  = ch_code[CH_SEL];
  // take against empty storage is a no-op, even if a push lands this cycle.
  assign pop      = take && coin_pending;

  // Selection: a new event beats a coincident take.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      sel_code <= '0;
    else if (sel_ev) sel_code <= sel_val;
    else if (take)   sel_code <= '0;
  end

`ifdef COIN_FIFO_EN
  logic [1:0] mem [4];
  logic [1:0] wr_ptr, rd_ptr, rd_nxt;
  logic [2:0] count, count_nxt;
  logic       full, do_push, drop;
  logic [1:0] head_nxt;

  always_comb begin
    full      = (count == 3'd4);
    do_push   = coin_ev && (!full || pop);
    drop      = coin_ev && full && !pop;
    rd_nxt    = rd_ptr + {1'b0, pop};
    count_nxt = count + {2'b00, do_push} - {2'b00, pop};
    // The new head is the slot being written this cycle when the push
    // lands exactly at the next read position (empty, or last entry popped).
    if (count_nxt == 3'd0)                 head_nxt = 2'b00;
    else if (do_push && rd_nxt == wr_ptr)  head_nxt = coin_val;
    else                                   head_nxt = mem[rd_nxt];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) mem[i] <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      coin_code    <= '0;
      coin_pending <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= coin_val;
        wr_ptr      <= wr_ptr + 2'd1;
      end
      rd_ptr       <= rd_nxt;
      count        <= count_nxt;
      coin_code    <= head_nxt;
      coin_pending <= (count_nxt != 3'd0);
      if (drop) overflow <= 1'b1;
    end
  end
`else
  logic do_push, drop;

  assign do_push = coin_ev && (!coin_pending || pop);
  assign drop    = coin_ev && coin_pending && !pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coin_code    <= '0;
      coin_pending <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      if (do_push) begin
        coin_code    <= coin_val;
        coin_pending <= 1'b1;
      end else if (pop) begin
        coin_code    <= '0;
        coin_pending <= 1'b0;
      end
      if (drop) overflow <= 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_vending_input_conditioner.sv
// Bench for vending_input_conditioner. Directed scenarios plus a random
// run against a reference model. The model treats a code as stable once the
// last DEBOUNCE_CYCLES samples of the raw code agree, allowing for the
// two-flop synchroniser. It keeps coin storage as a queue.
module tb_vending_input_conditioner;
  localparam int D = 16;
`ifdef COIN_FIFO_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] coin_raw = 2'b00;
  logic [1:0] sel_raw = 2'b00;
  logic       take = 1'b0;
  logic [1:0] coin_code, sel_code;
  logic       coin_pending, overflow;

  int n_checks = 0;
  int n_fail = 0;

  vending_input_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .coin_raw    (coin_raw),
    .sel_raw     (sel_raw),
    .take        (take),
    .coin_code   (coin_code),
    .coin_pending(coin_pending),
    .sel_code    (sel_code),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [1:0] h_coin [D+2];   // h[0] = raw sampled at the current edge
  logic [1:0] h_sel  [D+2];
  logic [1:0] m_st_c, m_pv_c, m_st_s, m_pv_s;
  logic [1:0] m_q[$];
  logic [1:0] m_sel;
  logic       m_ovf;

  // Raw samples two edges back and older have passed the synchroniser.
  // D of them in a row fix the stable code.
  function automatic bit run_of(input logic [1:0] h [D+2], output logic [1:0] v);
    v = h[2];
    for (int i = 3; i <= D + 1; i++) if (h[i] !== v) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < D + 2; i++) begin
      h_coin[i] = 2'b00;
      h_sel[i]  = 2'b00;
    end
    m_st_c = 0; m_pv_c = 0; m_st_s = 0; m_pv_s = 0;
    m_q.delete();
    m_sel = 0;
    m_ovf = 0;
  endtask

  task automatic model_edge();
    bit ev_c, ev_s, pop;
    logic [1:0] v;
    if (!rst_n) begin
      model_reset();
      return;
    end
    ev_c = (m_st_c != 0) && (m_pv_c == 0);
    ev_s = (m_st_s != 0) && (m_pv_s == 0);
    pop  = take && (m_q.size() > 0);
    if (pop) void'(m_q.pop_front());
    if (ev_c) begin
      if (m_q.size() < CAP) m_q.push_back(m_st_c);
      else m_ovf = 1'b1;
    end
    if (ev_s) m_sel = m_st_s;
    else if (take) m_sel = 2'b00;
    for (int i = D + 1; i > 0; i--) begin
      h_coin[i] = h_coin[i-1];
      h_sel[i]  = h_sel[i-1];
    end
    h_coin[0] = coin_raw;
    h_sel[0]  = sel_raw;
    m_pv_c = m_st_c;
    m_pv_s = m_st_s;
    if (run_of(h_coin, v)) m_st_c = v;
    if (run_of(h_sel, v))  m_st_s = v;
  endtask

  function automatic logic [5:0] model_out();
    logic [1:0] hc;
    hc = (m_q.size() > 0) ? m_q[0] : 2'b00;
    return {hc, logic'(m_q.size() > 0), m_sel, m_ovf};
  endfunction

  // Inputs change on negedge, so they are stable at posedge. Outputs are read after the negedge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_take();
    take = 1'b1;
    step();
    take = 1'b0;
  endtask

  task automatic press_coin(input logic [1:0] c);
    coin_raw = c;
    steps(20);
    coin_raw = 2'b00;
    steps(20);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++; if (coin_code !== 2'b00) begin n_fail++; $display("FAIL reset_coin_code got=%b exp=00", coin_code); end
    n_checks++; if (coin_pending !== 1'b0) begin n_fail++; $display("FAIL reset_coin_pending got=%b exp=0", coin_pending); end
    n_checks++; if (sel_code !== 2'b00) begin n_fail++; $display("FAIL reset_sel_code got=%b exp=00", sel_code); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    rst_n = 1'b1;
    steps(3);
    n_checks++;
    if ({coin_code, coin_pending, sel_code, overflow} !== 6'b0) begin
      n_fail++; $display("FAIL reset_release_idle got=%b exp=000000", {coin_code, coin_pending, sel_code, overflow});
    end
  endtask

  task automatic test_bounce();
    for (int s = 0; s < 12; s++) begin
      coin_raw = s[0] ? 2'b01 : 2'b00;
      for (int i = 0; i < 5; i++) begin
        step();
        n_checks++;
        if ({coin_pending, coin_code} !== 3'b000) begin
          n_fail++; $display("FAIL bounce_no_event got=%b exp=000", {coin_pending, coin_code});
        end
      end
    end
    coin_raw = 2'b00;
    for (int i = 0; i < 30; i++) begin
      step();
      n_checks++;
      if ({coin_pending, coin_code} !== 3'b000) begin
        n_fail++; $display("FAIL bounce_tail_no_event got=%b exp=000", {coin_pending, coin_code});
      end
    end
  endtask

  task automatic test_clean_coin();
    coin_raw = 2'b10;   // first sampled at edge N = step 1
    for (int i = 1; i <= 30; i++) begin
      step();
      if (i == 18) begin
        n_checks++;
        if (coin_pending !== 1'b0) begin n_fail++; $display("FAIL clean_coin_early got=%b exp=0", coin_pending); end
      end
      if (i == 19) begin
        n_checks++;
        if ({coin_code, coin_pending} !== 3'b101) begin
          n_fail++; $display("FAIL clean_coin_latency got=%b exp=101", {coin_code, coin_pending});
        end
      end
    end
    pulse_take();
    n_checks++;
    if ({coin_code, coin_pending} !== 3'b000) begin
      n_fail++; $display("FAIL clean_coin_take got=%b exp=000", {coin_code, coin_pending});
    end
    steps(10);
    coin_raw = 2'b00;
    steps(20);
    n_checks++;
    if ({coin_code, coin_pending, overflow} !== 4'b0000) begin
      n_fail++; $display("FAIL clean_coin_single_event got=%b exp=0000", {coin_code, coin_pending, overflow});
    end
  endtask

`ifdef COIN_FIFO_EN
  task automatic test_coin_fifo();
    logic [1:0] seq [5];
    seq[0] = 2'b01; seq[1] = 2'b10; seq[2] = 2'b11; seq[3] = 2'b01; seq[4] = 2'b10;
    for (int i = 0; i < 3; i++) press_coin(seq[i]);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({coin_code, coin_pending} !== {seq[i], 1'b1}) begin
        n_fail++; $display("FAIL fifo_order[%0d] got=%b exp=%b1", i, {coin_code, coin_pending}, seq[i]);
      end
      pulse_take();
    end
    n_checks++;
    if ({coin_code, coin_pending, overflow} !== 4'b0000) begin
      n_fail++; $display("FAIL fifo_drained got=%b exp=0000", {coin_code, coin_pending, overflow});
    end
    for (int i = 0; i < 5; i++) press_coin(seq[i]);
    n_checks++;
    if (overflow !== 1'b1) begin n_fail++; $display("FAIL fifo_overflow got=%b exp=1", overflow); end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({coin_code, coin_pending} !== {seq[i], 1'b1}) begin
        n_fail++; $display("FAIL fifo_full_order[%0d] got=%b exp=%b1", i, {coin_code, coin_pending}, seq[i]);
      end
      pulse_take();
    end
    n_checks++;
    if ({coin_code, coin_pending} !== 3'b000) begin
      n_fail++; $display("FAIL fifo_fifth_dropped got=%b exp=000", {coin_code, coin_pending});
    end
  endtask
`else
  task automatic test_coin_single();
    press_coin(2'b01);
    press_coin(2'b11);
    n_checks++;
    if ({coin_code, coin_pending, overflow} !== 4'b0111) begin
      n_fail++; $display("FAIL single_keep_first got=%b exp=0111", {coin_code, coin_pending, overflow});
    end
    pulse_take();
    n_checks++;
    if ({coin_code, coin_pending, overflow} !== 4'b0001) begin
      n_fail++; $display("FAIL single_take got=%b exp=0001", {coin_code, coin_pending, overflow});
    end
  endtask
`endif

  task automatic test_selection();
    sel_raw = 2'b11;
    steps(20);
    sel_raw = 2'b00;
    steps(20);
    n_checks++;
    if (sel_code !== 2'b11) begin n_fail++; $display("FAIL sel_first got=%b exp=11", sel_code); end
    sel_raw = 2'b01;
    steps(18);            // edges N..N+17
    n_checks++;
    if (sel_code !== 2'b11) begin n_fail++; $display("FAIL sel_before_event got=%b exp=11", sel_code); end
    pulse_take();         // edge N+18: event and take coincide
    n_checks++;
    if (sel_code !== 2'b01) begin n_fail++; $display("FAIL sel_event_beats_take got=%b exp=01", sel_code); end
    pulse_take();
    n_checks++;
    if (sel_code !== 2'b00) begin n_fail++; $display("FAIL sel_take_clears got=%b exp=00", sel_code); end
    sel_raw = 2'b10;      // no 00 in between
    steps(25);
    n_checks++;
    if (sel_code !== 2'b00) begin n_fail++; $display("FAIL sel_nz_to_nz got=%b exp=00", sel_code); end
    sel_raw = 2'b00;
    steps(20);
  endtask

  task automatic test_reset_mid();
    press_coin(2'b11);
    n_checks++;
    if (coin_pending !== 1'b1) begin n_fail++; $display("FAIL rstmid_setup got=%b exp=1", coin_pending); end
    coin_raw = 2'b01;
    steps(8);
    #2 rst_n = 1'b0;
    model_reset();
    coin_raw = 2'b00;
    #1;
    n_checks++;
    if ({coin_code, coin_pending, sel_code, overflow} !== 6'b0) begin
      n_fail++; $display("FAIL rstmid_async got=%b exp=000000", {coin_code, coin_pending, sel_code, overflow});
    end
    @(negedge clk);
    steps(3);
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      n_checks++;
      if ({coin_code, coin_pending, sel_code, overflow} !== 6'b0) begin
        n_fail++; $display("FAIL rstmid_no_event got=%b exp=000000", {coin_code, coin_pending, sel_code, overflow});
      end
    end
    press_coin(2'b10);
    n_checks++;
    if ({coin_code, coin_pending} !== 3'b101) begin
      n_fail++; $display("FAIL rstmid_fresh_press got=%b exp=101", {coin_code, coin_pending});
    end
    pulse_take();
  endtask

  task automatic test_random();
    int rem_c, rem_s;
    logic [5:0] exp;
    rem_c = 0; rem_s = 0;
    for (int i = 0; i < 1500; i++) begin
      if (rem_c == 0) begin
        coin_raw = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
        rem_c = $urandom_range(1, 30);
      end
      if (rem_s == 0) begin
        sel_raw = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
        rem_s = $urandom_range(1, 30);
      end
      rem_c--; rem_s--;
      take = ($urandom_range(0, 7) == 0);
      step();
      exp = model_out();
      n_checks++;
      if ({coin_code, coin_pending, sel_code, overflow} !== exp) begin
        n_fail++; $display("FAIL random[%0d] got=%b exp=%b", i, {coin_code, coin_pending, sel_code, overflow}, exp);
      end
    end
    take = 1'b0;
    coin_raw = 2'b00;
    sel_raw = 2'b00;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_bounce();
    test_clean_coin();
`ifdef COIN_FIFO_EN
    test_coin_fifo();
`else
    test_coin_single();
`endif
    test_selection();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/vending_input_conditioner.md
# vending_input_conditioner

Front-end stage for the coin/selection vending FSM. It synchronises and debounces the raw 2-bit coin code and 2-bit selection code from the pads. Each accepted coin insertion and each selection press becomes a single event. Events are held until the FSM consumes them on its slow-clock sampling strobe, so no press is lost or double-counted across the fast/slow rate boundary.

## Interface
Parameters:
- DEBOUNCE_CYCLES, default 16: consecutive identical synchronised samples required before a new input code is accepted; legal range 2..65535.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- coin_raw  input  2  raw coin code from pads: 00 none, 01/10/11 coin denominations.
- sel_raw  input  2  raw selection code from pads: 00 none, 01/10/11 product.
- take  input  1  one-cycle strobe, asserted when the downstream FSM samples this block's outputs.
- coin_code  output  2  head coin event; 00 when no coin pending.
- coin_pending  output  1  high when at least one coin event is held.
- sel_code  output  2  held selection event; 00 when none.
- overflow  output  1  sticky; set when a coin event is dropped; cleared only by reset.

## Operation
- Synchroniser: two-flop chain on each of the 4 raw bits.
- Debounce, per channel (coin and selection independent, each treats its 2-bit code as a unit):
  - Registers: candidate code, counter, stable code.
  - Synchronised code differs from candidate: load candidate, clear counter.
  - Equal to candidate: counter increments, saturating.
  - Counter reaches DEBOUNCE_CYCLES-1 with equal input: stable code <= candidate.
- Event detection on stable code: transition from 00 to nonzero X produces one event carrying X.
  - Nonzero-to-nonzero changes produce no event; the input must return to 00 first.
  - Holding a code produces exactly one event.
- Coin storage:
  - Coin event pushes X into coin storage (see Configuration).
  - coin_code/coin_pending present the storage head, registered.
  - take with coin_pending=1 pops the head.
  - take with storage empty has no effect.
- Selection storage: single register.
  - Selection event loads sel_code <= X.
  - take clears sel_code to 00.
  - take and a new selection event in the same cycle: the new event wins (sel_code <= X).
- Simultaneous coin push and pop:
  - Storage not empty: both happen; occupancy unchanged.
  - Storage empty: the new event is stored and appears next cycle; take is ignored.
- Overflow: a coin event arriving while storage is full and no pop occurs in the same cycle is dropped and sets overflow.

## Timing
- Reset (asynchronous assert, synchronous release):
  - Synchroniser flops, candidate and stable codes <= 00; counters <= 0.
  - Storage emptied; coin_code=00, coin_pending=0, sel_code=00, overflow=0.
- Reset mid-debounce or with events pending discards everything; no event is emitted after release until a fresh 00->nonzero press completes debounce.
- Latency: raw code first sampled at edge N and held constant:
  - stable code updates at edge N+1+DEBOUNCE_CYCLES;
  - coin_code/sel_code/coin_pending reflect the event at edge N+2+DEBOUNCE_CYCLES.
  - Default parameter: 18 cycles.
- Any bounce shorter than DEBOUNCE_CYCLES synchronised cycles restarts the count and produces no event.
- take is sampled on the same clk edge; outputs reflect the pop one cycle later.
- Outputs are registered; no combinational path from inputs to outputs.

## Configuration
- COIN_FIFO_EN defined:
  - Coin storage is a 4-entry FIFO with 2-bit read/write pointers that wrap modulo 4 and a 3-bit count.
  - Order is preserved; full = count 4.
  - The 5th unconsumed event sets overflow.
- COIN_FIFO_EN undefined:
  - Coin storage is a single holding register; full = coin_pending.
  - A second event before take sets overflow.
  - coin_code keeps the first value.

## Test plan
- Bounce rejection: coin_raw toggles 00/01 every 5 cycles for 60 cycles, then held 00 -> coin_pending stays 0, coin_code stays 00.
- Clean coin: coin_raw=10 held 30 cycles from edge N -> coin_code=10 and coin_pending=1 at edge N+18. Then take pulse -> coin_code=00, coin_pending=0 the next cycle. Holding longer yields no second event.
- FIFO order (COIN_FIFO_EN): coins 01, 10, 11 inserted with no take -> three takes return 01, 10, 11 in order. A 5th unconsumed coin -> overflow=1; the first four are still delivered.
- Single register (no COIN_FIFO_EN): coins 01 then 11 with no take -> coin_code=01, overflow=1. After take, coin_code=00.
- Selection: sel_raw=11 pressed, released, then 01 pressed with take coinciding with the 01 event -> sel_code=01 afterwards. A nonzero-to-nonzero change 01->10 without 00 in between -> no new event.
- Reset mid-operation: rst_n low for 3 cycles while coin_pending=1 and a press is half-debounced -> all outputs 0 immediately. No event after release unless the press restarts from 00.
